picoramsoc_ram_arbiter: RTL and testbench

//  Shares the single read/write port of the SoC's synchronous on-chip RAM between two bus masters.
//  m0 is the CPU data port; m1 is a loader/DMA master.

---
 rtl/picoramsoc_pkg.sv | 28 ++
 rtl/picoramsoc_rr_pick.sv | 28 ++
 rtl/picoramsoc_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_picoramsoc_ram_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/picoramsoc_pkg.sv
// Shared types and constants for the on-chip RAM arbiter slice.
package picoramsoc_pkg;

    // Arbiter FSM: one idle cycle to pick and launch, one cycle to complete.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Master indices into the request/response vectors.
    localparam int M_CPU = 0;
    localparam int M_DMA = 1;
    localparam int NUM_M = 2;

    // Native bus widths.
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;

    // One master's request as seen by the arbiter.
    typedef struct packed {
        logic              valid;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/picoramsoc_rr_pick.sv
// Combinational 2-way round-robin picker with an m1 lock override.
module picoramsoc_rr_pick
    import picoramsoc_pkg::*;
(
    input  logic [NUM_M-1:0] req_i,
    input  logic             last_grant_i,
    input  logic             lock_ok_i,
    output logic [NUM_M-1:0] win_o
);

    // Lone requester wins; on contention the lock override beats alternation.
    always_comb begin
        win_o = '0;
        case (req_i)
            2'b01: win_o[M_CPU] = 1'b1;
            2'b10: win_o[M_DMA] = 1'b1;
            2'b11: begin
                if (lock_ok_i || (last_grant_i == 1'(M_CPU))) begin
                    win_o[M_DMA] = 1'b1;
                end else begin
                    win_o[M_CPU] = 1'b1;
                end
            end
            default: win_o = '0;
        endcase
    end

endmodule

// File: rtl/picoramsoc_ram_arbiter.sv
// Two-master arbiter for the single port of the synchronous on-chip RAM.
// Each access takes one IDLE (launch) cycle and one ACCESS (complete) cycle.
module picoramsoc_ram_arbiter
    import picoramsoc_pkg::*;
#(
    parameter int WORDS    = 4096,
    parameter int AW       = 22,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,
    output logic [STRB_W-1:0] ram_wen,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [NUM_M-1:0]  grant,
    output logic              addr_err
);

    localparam int             CW         = $clog2(MAX_LOCK + 1);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * WORDS);

    bus_req_t          req [NUM_M];
    bus_req_t          win;
    logic [NUM_M-1:0]  req_vec, win_oh, ready_vec;
    logic [DATA_W-1:0] rdata_arr [NUM_M];
    logic              win_idx, any_req, launch, in_range_now, lock_ok, override_take;
    logic              unused_bits;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              in_range_q, in_range_d;
    logic              last_grant_q, last_grant_d;
    logic              lock_prev_q, lock_prev_d;
    logic [NUM_M-1:0]  grant_q, grant_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    assign req[M_CPU] = '{valid: m0_valid, wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
    assign req[M_DMA] = '{valid: m1_valid, wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_master
            assign req_vec[gi]   = req[gi].valid;
            // Only the owner sees ready; out-of-range reads return zero.
            assign ready_vec[gi] = (state_q == ST_ACCESS) && (owner_q == 1'(gi));
            assign rdata_arr[gi] = (ready_vec[gi] && in_range_q) ? ram_rdata : '0;
        end
    endgenerate

    // Lock only applies while the previous access was a locked m1 and budget remains.
    assign lock_ok       = lock_prev_q && (lock_cnt_q < CW'(MAX_LOCK));
    assign any_req       = |req_vec;
    assign launch        = (state_q == ST_IDLE) && any_req;
    assign override_take = launch && (&req_vec) && lock_ok;

    picoramsoc_rr_pick u_pick (
        .req_i        (req_vec),
        .last_grant_i (last_grant_q),
        .lock_ok_i    (lock_ok),
        .win_o        (win_oh)
    );

    assign win_idx      = win_oh[M_DMA];
    assign win          = req[win_idx];
    assign in_range_now = ({1'b0, win.addr} < ADDR_LIMIT);
    assign unused_bits  = ^{win.valid, win.addr[1:0], win.addr[ADDR_W-1:AW+2]};

    // State register; an asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: launch from IDLE on any request, ACCESS always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bookkeeping next-state: owner capture on launch, fairness/lock history on completion.
    always_comb begin
        owner_d      = owner_q;
        in_range_d   = in_range_q;
        last_grant_d = last_grant_q;
        lock_prev_d  = lock_prev_q;
        lock_cnt_d   = lock_cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        grant_d      = '0;
        if (launch) begin
            owner_d     = win_idx;
            in_range_d  = in_range_now;
            grant_d     = win_oh;
            ram_addr_d  = win.addr[AW+1:2];
            ram_wdata_d = win.wdata;
            if (win_idx == 1'(M_CPU))  lock_cnt_d = '0;
            else if (override_take)    lock_cnt_d = lock_cnt_q + CW'(1);
        end
        if (state_q == ST_ACCESS) begin
            last_grant_d = owner_q;
            lock_prev_d  = (owner_q == 1'(M_DMA)) && m1_lock;
            if ((owner_q == 1'(M_DMA)) && !m1_lock) lock_cnt_d = '0;
        end
    end

    // Bookkeeping registers; last_grant resets to m1 so m0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'(M_CPU);
            in_range_q   <= 1'b0;
            last_grant_q <= 1'(M_DMA);
            lock_prev_q  <= 1'b0;
            lock_cnt_q   <= '0;
            grant_q      <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            in_range_q   <= in_range_d;
            last_grant_q <= last_grant_d;
            lock_prev_q  <= lock_prev_d;
            lock_cnt_q   <= lock_cnt_d;
            grant_q      <= grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Outputs: RAM port driven by the winner during launch, responses during ACCESS.
    always_comb begin
        ram_wen   = '0;
        if (launch && in_range_now) ram_wen = win.wstrb;
        ram_addr  = ram_addr_d;
        ram_wdata = ram_wdata_d;
        addr_err  = (state_q == ST_ACCESS) && !in_range_q;
        grant     = grant_q;
        m0_ready  = ready_vec[M_CPU];
        m1_ready  = ready_vec[M_DMA];
        m0_rdata  = rdata_arr[M_CPU];
        m1_rdata  = rdata_arr[M_DMA];
    end

endmodule

// File: tb/tb_picoramsoc_ram_arbiter.sv
// Directed self-checking bench for picoramsoc_ram_arbiter with a behavioural RAM.
module tb_picoramsoc_ram_arbiter;

    localparam int WORDS = 4096;
    localparam int AW    = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 0, m1_valid = 0, m1_lock = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic        m0_ready, m1_ready, addr_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [1:0]  grant;

    logic [31:0] mem [WORDS];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    picoramsoc_ram_arbiter #(.WORDS(WORDS), .AW(AW), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .grant(grant), .addr_err(addr_err)
    );

    // Synchronous RAM: byte-enabled write, registered read (old data on collision).
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_addr[11:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A pending request must stay valid until its ready pulse.
    logic pend0 = 0, pend1 = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (pend0 && !m0_ready) check("proto_m0_hold", m0_valid, 1'b1);
            if (pend1 && !m1_ready) check("proto_m1_hold", m1_valid, 1'b1);
            pend0 <= m0_valid && !m0_ready;
            pend1 <= m1_valid && !m1_ready;
        end
    end

    // Single-master access; checks one-cycle latency and returns the response.
    task automatic do_access(input int m, input logic [3:0] strb, input logic [31:0] addr,
                             input logic [31:0] wdata, input string tag,
                             output logic [31:0] rdata, output logic err,
                             output logic [3:0] wen_seen, output logic [1:0] gnt);
        int lat;
        logic rdy;
        @(negedge clk);
        if (m == 0) begin m0_valid = 1; m0_wstrb = strb; m0_addr = addr; m0_wdata = wdata; end
        else        begin m1_valid = 1; m1_wstrb = strb; m1_addr = addr; m1_wdata = wdata; end
        #1 wen_seen = ram_wen;
        rdy = 0;
        for (lat = 1; lat <= 8; lat++) begin
            @(posedge clk); #1;
            rdy = (m == 0) ? m0_ready : m1_ready;
            if (rdy) break;
        end
        rdata = (m == 0) ? m0_rdata : m1_rdata;
        err   = addr_err;
        gnt   = grant;
        check({tag, "_latency"}, lat, 1);
        @(negedge clk);
        if (m == 0) begin m0_valid = 0; m0_wstrb = 0; end
        else        begin m1_valid = 0; m1_wstrb = 0; end
        $display("txn %s m%0d strb=%b addr=%h wdata=%h rdata=%h err=%b grant=%b lat=%0d",
                 tag, m, strb, addr, wdata, rdata, err, gnt, lat);
    endtask

    // Contention run: both masters already valid; records the first n grants, then drains.
    logic [1:0] gseq [16];
    int         gcnt;
    logic       nonown_bad;
    task automatic run_grants(input int n);
        gcnt = 0;
        nonown_bad = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            if (grant != 2'b00) begin
                if (grant == 2'b01 && (m1_ready !== 1'b0 || m1_rdata !== 32'h0)) nonown_bad = 1;
                if (grant == 2'b10 && (m0_ready !== 1'b0 || m0_rdata !== 32'h0)) nonown_bad = 1;
                if (gcnt < n) begin
                    gseq[gcnt] = grant;
                    $display("txn contention grant#%0d grant=%b", gcnt, grant);
                    gcnt++;
                end else begin
                    if (m0_ready) m0_valid = 0;
                    if (m1_ready) begin m1_valid = 0; m1_lock = 0; end
                end
            end
            if (!m0_valid && !m1_valid) break;
        end
        check("drain_done", {31'b0, m0_valid | m1_valid}, 32'h0);
        @(negedge clk);
        m0_valid = 0; m1_valid = 0; m1_lock = 0;
    endtask

    logic [31:0] r;
    logic        e;
    logic [3:0]  w;
    logic [1:0]  g;
    logic [1:0]  exp3 [4];
    logic [1:0]  exp4 [12];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'(i);
        mem[0]    = 32'h0BADF00D;
        mem[4]    = 32'hFFFFFFFF;
        mem[12'h40] = 32'hDEADBEEF;
        exp3 = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

        // T1: reset values, then first read
        repeat (3) @(negedge clk);
        check("t1_rst_m0_ready", m0_ready, 0);
        check("t1_rst_m1_ready", m1_ready, 0);
        check("t1_rst_grant", grant, 0);
        check("t1_rst_addr_err", addr_err, 0);
        check("t1_rst_ram_wen", ram_wen, 0);
        reset = 0;
        do_access(0, 4'b0000, 32'h100, 32'h0, "t1_read", r, e, w, g);
        check("t1_rdata", r, 32'hDEADBEEF);
        check("t1_grant", g, 2'b01);
        check("t1_addr_err", e, 0);

        // T2: partial write then read back
        do_access(1, 4'b0011, 32'h10, 32'h12345678, "t2_write", r, e, w, g);
        check("t2_wen", w, 4'b0011);
        check("t2_grant", g, 2'b10);
        do_access(1, 4'b0000, 32'h10, 32'h0, "t2_read", r, e, w, g);
        check("t2_rdata", r, 32'hFFFF5678);

        // T3: contention alternates starting with m0
        @(negedge clk);
        m0_valid = 1; m0_wstrb = 0; m0_addr = 32'h100;
        m1_valid = 1; m1_wstrb = 0; m1_addr = 32'h10;
        run_grants(4);
        check("t3_count", gcnt, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), gseq[i], exp3[i]);
        check("t3_nonowner_quiet", nonown_bad, 0);

        // T4: lock override, budget of 4, counter cleared by the m0 grant
        do_access(0, 4'b0000, 32'h100, 32'h0, "t4_pre", r, e, w, g);
        @(negedge clk);
        m0_valid = 1; m0_wstrb = 0; m0_addr = 32'h100;
        m1_valid = 1; m1_wstrb = 0; m1_addr = 32'h10; m1_lock = 1;
        run_grants(12);
        check("t4_count", gcnt, 12);
        for (int i = 0; i < 12; i++) check($sformatf("t4_grant%0d", i), gseq[i], exp4[i]);

        // T5: out-of-range write and read
        do_access(0, 4'b1111, 32'h4000, 32'hAAAA5555, "t5_write", r, e, w, g);
        check("t5_wen", w, 4'b0000);
        check("t5_addr_err", e, 1);
        check("t5_no_alias_write", mem[0], 32'h0BADF00D);
        do_access(0, 4'b0000, 32'h4000, 32'h0, "t5_read", r, e, w, g);
        check("t5_rdata", r, 32'h0);
        check("t5_read_err", e, 1);

        // T6: asynchronous reset during ACCESS
        @(negedge clk);
        m0_valid = 1; m0_wstrb = 0; m0_addr = 32'h100;
        @(posedge clk); #1;
        check("t6_ready_before", m0_ready, 1);
        #2 reset = 1;
        #1;
        check("t6_ready_dropped", m0_ready, 0);
        check("t6_grant_cleared", grant, 0);
        $display("txn t6_reset_mid_access m0_ready=%b grant=%b", m0_ready, grant);
        @(negedge clk);
        reset = 0; m0_valid = 0;
        do_access(0, 4'b0000, 32'h100, 32'h0, "t6_after", r, e, w, g);
        check("t6_rdata", r, 32'hDEADBEEF);
        do_access(1, 4'b0000, 32'h10, 32'h0, "t6_m1", r, e, w, g);
        check("t6_m1_rdata", r, 32'hFFFF5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
